// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master sequencing controller.
package i2c_pkg;

  // Bus-level sequencing states.
  typedef enum logic [3:0] {
    IDLE,
    START,
    WRITE_ADDR,
    READ_ADDR_ACK,
    WRITE_DATA,
    READ_DATA_ACK,
    READ_DATA,
    WRITE_ACK,
    STOP,
    REPEAT_START
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned PRESCALE_MIN  = 2;
  localparam int unsigned BITS_PER_BYTE = 8;

  // One-hot phase strobes presented to the datapath.
  typedef struct packed {
    logic start;
    logic write_addr;
    logic write_data;
    logic read_data;
    logic write_ack;
    logic read_ack;
    logic stop;
    logic repeat_start;
  } i2c_phase_t;

  // Map a state onto its phase strobe; both slave-ACK states share read_ack.
  function automatic i2c_phase_t phase_decode(input i2c_state_e s);
    i2c_phase_t p;
    p = '0;
    case (s)
      START:         p.start        = 1'b1;
      WRITE_ADDR:    p.write_addr   = 1'b1;
      READ_ADDR_ACK: p.read_ack     = 1'b1;
      WRITE_DATA:    p.write_data   = 1'b1;
      READ_DATA_ACK: p.read_ack     = 1'b1;
      READ_DATA:     p.read_data    = 1'b1;
      WRITE_ACK:     p.write_ack    = 1'b1;
      STOP:          p.stop         = 1'b1;
      REPEAT_START:  p.repeat_start = 1'b1;
      default:       p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_fsm_if.sv
// Command, handshake and bus-phase signals of the I2C master controller.
// Optional macro I2C_CLK_STRETCH_EN adds the scl_i sense line.
interface i2c_master_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [7:0]       addr_rw_i;
  logic [7:0]       num_bytes_i;
  logic             repeat_start_i;
  logic [CNT_W-1:0] prescaler_i;
  logic             sda_i;
`ifdef I2C_CLK_STRETCH_EN
  logic             scl_i;
`endif
  logic             tx_req_o;
  logic             rx_valid_o;
  logic             ack_bit_o;
  logic             start_cnt_o;
  logic             write_addr_cnt_o;
  logic             write_data_cnt_o;
  logic             read_data_cnt_o;
  logic             write_ack_cnt_o;
  logic             read_ack_cnt_o;
  logic             stop_cnt_o;
  logic             repeat_start_cnt_o;
  logic [CNT_W-1:0] counter_detect_edge_o;
  logic [7:0]       counter_state_done_time_repeat_start_o;
  logic             scl_o;
  logic             busy_o;
  logic             done_o;
  logic             nack_o;

  // Controller side.
  modport master (
`ifdef I2C_CLK_STRETCH_EN
    input  scl_i,
`endif
    input  cmd_valid_i, addr_rw_i, num_bytes_i, repeat_start_i, prescaler_i, sda_i,
    output cmd_ready_o, tx_req_o, rx_valid_o, ack_bit_o,
    output start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o,
    output write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o,
    output counter_detect_edge_o, counter_state_done_time_repeat_start_o,
    output scl_o, busy_o, done_o, nack_o
  );

  // Requester / datapath side.
  modport slave (
`ifdef I2C_CLK_STRETCH_EN
    output scl_i,
`endif
    output cmd_valid_i, addr_rw_i, num_bytes_i, repeat_start_i, prescaler_i, sda_i,
    input  cmd_ready_o, tx_req_o, rx_valid_o, ack_bit_o,
    input  start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o,
    input  write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o,
    input  counter_detect_edge_o, counter_state_done_time_repeat_start_o,
    input  scl_o, busy_o, done_o, nack_o
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// SCL phase counter: counts 0..2P-1, drives SCL low for the first half.
// Optional macro I2C_CLK_STRETCH_EN holds the count while a slave stretches SCL.
module i2c_scl_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic             force_high_i,
`ifdef I2C_CLK_STRETCH_EN
  input  logic             scl_i,
`endif
  output logic [CNT_W:0]   cnt_o,
  output logic             scl_o,
  output logic             step_c,
  output logic             wrap_c
);
  localparam int unsigned PW = CNT_W + 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic          scl_q, scl_d;
  logic [PW-1:0] period_w;
  logic [PW-1:0] last_w;
  logic          stall_c;

  assign period_w = PW'(period_i);
  assign last_w   = (period_w << 1) - PW'(1);

  // Stretch detect: SCL released high but the line is still held low.
`ifdef I2C_CLK_STRETCH_EN
  assign stall_c = scl_q && !scl_i && (cnt_q == period_w + PW'(1));
`else
  assign stall_c = 1'b0;
`endif

  assign step_c = run_i && !stall_c;
  assign wrap_c = step_c && (cnt_q == last_w);

  // Next count and next SCL level.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_c) begin
      cnt_d = wrap_c ? '0 : cnt_q + PW'(1);
    end
    scl_d = force_high_i || (cnt_d >= period_w);
  end

  // Counter and SCL registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      scl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      scl_q <= scl_d;
    end
  end

  assign cnt_o = cnt_q;
  assign scl_o = scl_q;

endmodule

// File: rtl/i2c_master_ctrl_fsm.sv
// I2C master sequencing controller: runs one command (address, data bytes,
// STOP or repeated start) and emits SCL plus one-hot phase strobes.
// Optional macro I2C_CLK_STRETCH_EN enables slave clock stretching via scl_i.
module i2c_master_ctrl_fsm
  import i2c_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RS_HOLD = 4
) (
  input logic                  i2c_core_clock_i,
  input logic                  reset_bit_i,
  i2c_master_ctrl_fsm_if.master bus
);
  localparam int unsigned PW     = CNT_W + 1;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned RS_W   = 8;

  i2c_state_e       state_q, state_d;
  logic             rw_q, rw_d;
  logic             rs_en_q, rs_en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [BYTE_W-1:0] bytes_q, bytes_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [RS_W-1:0]  rs_cnt_q, rs_cnt_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             tx_req_q, tx_req_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ack_bit_q, ack_bit_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  i2c_phase_t       phase_q, phase_d;

  logic [PW-1:0]    cnt_w;
  logic [PW-1:0]    period_x;
  logic [CNT_W-1:0] period_clamp_c;
  logic             step_c, wrap_c, run_c, clear_c, force_high_c;
  logic             last_bit_c, last_byte_c, rs_high_c;
  i2c_state_e       end_state_c;

  assign period_x       = PW'(period_q);
  assign period_clamp_c = (bus.prescaler_i < CNT_W'(PRESCALE_MIN)) ?
                          CNT_W'(PRESCALE_MIN) : bus.prescaler_i;
  assign last_bit_c     = (bit_q == BIT_W'(BITS_PER_BYTE - 1));
  assign last_byte_c    = (bytes_q == BYTE_W'(1));
  assign end_state_c    = rs_en_q ? REPEAT_START : STOP;
  assign rs_high_c      = (state_q == REPEAT_START) && (cnt_w >= period_x);

  // Counter runs in every active phase; it freezes once the repeated-start high window begins.
  assign run_c        = (state_q != IDLE) && !rs_high_c;
  assign clear_c      = (state_d == IDLE);
  assign force_high_c = (state_d == IDLE) || (state_d == START);

  i2c_scl_gen #(
    .CNT_W (CNT_W)
  ) u_scl_gen (
    .clk_i        (i2c_core_clock_i),
    .rst_i        (reset_bit_i),
    .period_i     (period_q),
    .run_i        (run_c),
    .clear_i      (clear_c),
    .force_high_i (force_high_c),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i        (bus.scl_i),
`endif
    .cnt_o        (cnt_w),
    .scl_o        (bus.scl_o),
    .step_c       (step_c),
    .wrap_c       (wrap_c)
  );

  // Next-state, transfer bookkeeping and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    rs_en_d    = rs_en_q;
    period_d   = period_q;
    bytes_d    = bytes_q;
    bit_d      = bit_q;
    rs_cnt_d   = rs_cnt_q;
    nack_d     = nack_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && ready_q) begin
          rw_d     = bus.addr_rw_i[0];
          rs_en_d  = bus.repeat_start_i;
          period_d = period_clamp_c;
          bytes_d  = (bus.num_bytes_i == '0) ? BYTE_W'(1) : bus.num_bytes_i;
          bit_d    = '0;
          nack_d   = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (wrap_c) begin
          bit_d   = '0;
          state_d = WRITE_ADDR;
        end
      end
      WRITE_ADDR: begin
        if (wrap_c) begin
          bit_d = bit_q + BIT_W'(1);
          if (last_bit_c) state_d = READ_ADDR_ACK;
        end
      end
      READ_ADDR_ACK: begin
        if (wrap_c) begin
          if (bus.sda_i == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = rw_q ? READ_DATA : WRITE_DATA;
          end
        end
      end
      WRITE_DATA: begin
        if (wrap_c) begin
          bit_d = bit_q + BIT_W'(1);
          if (last_bit_c) state_d = READ_DATA_ACK;
        end
      end
      READ_DATA_ACK: begin
        if (wrap_c) begin
          bytes_d = bytes_q - BYTE_W'(1);
          if (bus.sda_i == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = last_byte_c ? end_state_c : WRITE_DATA;
          end
        end
      end
      READ_DATA: begin
        if (wrap_c) begin
          bit_d = bit_q + BIT_W'(1);
          if (last_bit_c) state_d = WRITE_ACK;
        end
      end
      WRITE_ACK: begin
        if (wrap_c) begin
          bytes_d = bytes_q - BYTE_W'(1);
          state_d = last_byte_c ? end_state_c : READ_DATA;
        end
      end
      STOP: begin
        if (wrap_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      REPEAT_START: begin
        if (cnt_w == period_x - PW'(1)) begin
          rs_cnt_d = RS_W'(RS_HOLD);
        end else if (rs_high_c) begin
          if (rs_cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rs_cnt_d = rs_cnt_q - RS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_req_d   = (state_d == WRITE_DATA) && (state_q != WRITE_DATA);
    rx_valid_d = (state_q == READ_DATA) && last_bit_c && step_c &&
                 (cnt_w == (period_x << 1) - PW'(2));
    ack_bit_d  = ((state_d == WRITE_ACK) && (bytes_d != BYTE_W'(1))) ? I2C_ACK : I2C_NACK;
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    phase_d    = phase_decode(state_d);
  end

  // State and registered outputs; reset aborts any transfer without a STOP.
  always_ff @(posedge i2c_core_clock_i) begin
    if (reset_bit_i) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      rs_en_q    <= 1'b0;
      period_q   <= CNT_W'(PRESCALE_MIN);
      bytes_q    <= '0;
      bit_q      <= '0;
      rs_cnt_q   <= '0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_req_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      ack_bit_q  <= I2C_NACK;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      rs_en_q    <= rs_en_d;
      period_q   <= period_d;
      bytes_q    <= bytes_d;
      bit_q      <= bit_d;
      rs_cnt_q   <= rs_cnt_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      tx_req_q   <= tx_req_d;
      rx_valid_q <= rx_valid_d;
      ack_bit_q  <= ack_bit_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      phase_q    <= phase_d;
    end
  end

  assign bus.cmd_ready_o                            = ready_q;
  assign bus.busy_o                                 = busy_q;
  assign bus.done_o                                 = done_q;
  assign bus.nack_o                                 = nack_q;
  assign bus.tx_req_o                               = tx_req_q;
  assign bus.rx_valid_o                             = rx_valid_q;
  assign bus.ack_bit_o                              = ack_bit_q;
  assign bus.start_cnt_o                            = phase_q.start;
  assign bus.write_addr_cnt_o                       = phase_q.write_addr;
  assign bus.write_data_cnt_o                       = phase_q.write_data;
  assign bus.read_data_cnt_o                        = phase_q.read_data;
  assign bus.write_ack_cnt_o                        = phase_q.write_ack;
  assign bus.read_ack_cnt_o                         = phase_q.read_ack;
  assign bus.stop_cnt_o                             = phase_q.stop;
  assign bus.repeat_start_cnt_o                     = phase_q.repeat_start;
  assign bus.counter_detect_edge_o                  = CNT_W'(cnt_w);
  assign bus.counter_state_done_time_repeat_start_o = rs_cnt_q;

endmodule

// File: tb/tb_i2c_master_ctrl_fsm.sv
// Self-checking bench for i2c_master_ctrl_fsm: table of whole transfers plus
// hand-written sequences for counter shape, repeated start and reset abort.
module tb_i2c_master_ctrl_fsm;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RS_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  i2c_master_ctrl_fsm #(
    .CNT_W   (CNT_W),
    .RS_HOLD (RS_HOLD)
  ) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_i      (rst),
    .bus              (bus)
  );

  typedef struct {
    logic [7:0] addr_rw;
    logic [7:0] nbytes;
    logic       rs;
    logic [7:0] presc;
    logic       addr_nack;
    int busy;
    int tx;
    int rx;
    int done;
    int nack;
    int rises;
    int ack_n;
    int ack_hist;
    int stop_cyc;
    int data_cyc;
    int rack_cyc;
    int rs_cyc;
  } vec_t;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] strobes;
  assign strobes = {bus.start_cnt_o, bus.write_addr_cnt_o, bus.write_data_cnt_o,
                    bus.read_data_cnt_o, bus.write_ack_cnt_o, bus.read_ack_cnt_o,
                    bus.stop_cnt_o, bus.repeat_start_cnt_o};

  logic mon_en = 1'b0;
  int m_busy, m_tx, m_rx, m_done, m_rises, m_ack_n, m_ack_hist;
  int m_stop, m_data, m_rack, m_rs, m_onehot;
  logic scl_prev  = 1'b1;
  logic wack_prev = 1'b0;
  logic addr_nack = 1'b0;
  logic after_addr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Slave model: ACK everything except the address when asked to NACK it.
  always @(negedge clk) begin
    if (bus.write_addr_cnt_o) after_addr = 1'b1;
    else if (bus.write_data_cnt_o || bus.read_data_cnt_o || bus.start_cnt_o) after_addr = 1'b0;
    bus.sda_i = (bus.read_ack_cnt_o && after_addr) ? addr_nack : 1'b0;
  end

  // Transfer monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy_o)             m_busy  <= m_busy + 1;
      if (bus.tx_req_o)           m_tx    <= m_tx + 1;
      if (bus.rx_valid_o)         m_rx    <= m_rx + 1;
      if (bus.done_o)             m_done  <= m_done + 1;
      if (bus.scl_o && !scl_prev) m_rises <= m_rises + 1;
      if (bus.stop_cnt_o)         m_stop  <= m_stop + 1;
      if (bus.write_data_cnt_o || bus.read_data_cnt_o) m_data <= m_data + 1;
      if (bus.read_ack_cnt_o)     m_rack  <= m_rack + 1;
      if (bus.repeat_start_cnt_o) m_rs    <= m_rs + 1;
      if (bus.write_ack_cnt_o && !wack_prev) begin
        m_ack_hist <= (m_ack_hist << 1) | (bus.ack_bit_o ? 1 : 0);
        m_ack_n    <= m_ack_n + 1;
      end
      if ($countones(strobes) > 1 || (!bus.busy_o && strobes != 8'h00)) m_onehot <= m_onehot + 1;
    end
    scl_prev  <= bus.scl_o;
    wack_prev <= bus.write_ack_cnt_o;
  end

  task automatic clear_mon();
    m_busy = 0; m_tx = 0; m_rx = 0; m_done = 0; m_rises = 0; m_ack_n = 0;
    m_ack_hist = 0; m_stop = 0; m_data = 0; m_rack = 0; m_rs = 0; m_onehot = 0;
  endtask

  // Present a command at the falling edge; returns one cycle after acceptance.
  task automatic issue(input logic [7:0] ar, input logic [7:0] nb, input logic rs,
                       input logic [7:0] pr, input logic an);
    @(negedge clk);
    addr_nack          = an;
    bus.addr_rw_i      = ar;
    bus.num_bytes_i    = nb;
    bus.repeat_start_i = rs;
    bus.prescaler_i    = pr;
    bus.cmd_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid_i    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    // addr_rw nb rs presc an | busy tx rx done nack rises ack_n hist stop data rack rs
    vecs[0] = '{8'hA0, 8'd2, 1'b0, 8'd4, 1'b0, 232, 2, 0, 1, 0, 28, 0, 0, 8, 128, 24, 0};
    vecs[1] = '{8'hA1, 8'd3, 1'b0, 8'd3, 1'b0, 228, 0, 3, 1, 0, 37, 3, 1, 6, 144, 6, 0};
    vecs[2] = '{8'hA0, 8'd2, 1'b0, 8'd4, 1'b1,  88, 0, 0, 1, 1, 10, 0, 0, 8, 0, 8, 0};
    vecs[3] = '{8'h20, 8'd0, 1'b0, 8'd0, 1'b0,  80, 1, 0, 1, 0, 19, 0, 0, 4, 32, 8, 0};
    vecs[4] = '{8'h21, 8'd1, 1'b0, 8'd1, 1'b0,  80, 0, 1, 1, 0, 19, 1, 1, 4, 32, 4, 0};
    vecs[5] = '{8'h20, 8'd1, 1'b1, 8'd2, 1'b0,  83, 1, 0, 1, 0, 19, 0, 0, 0, 32, 8, 7};
    vecs[6] = '{8'h21, 8'd2, 1'b1, 8'd2, 1'b0, 119, 0, 2, 1, 0, 28, 2, 1, 0, 64, 4, 7};

    rst                = 1'b1;
    bus.cmd_valid_i    = 1'b0;
    bus.addr_rw_i      = 8'h00;
    bus.num_bytes_i    = 8'h00;
    bus.repeat_start_i = 1'b0;
    bus.prescaler_i    = '0;
    bus.sda_i          = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    bus.scl_i          = 1'b1;
`endif
    clear_mon();
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_ready",   int'(bus.cmd_ready_o), 1);
    chk("rst_scl",     int'(bus.scl_o), 1);
    chk("rst_busy",    int'(bus.busy_o), 0);
    chk("rst_done",    int'(bus.done_o), 0);
    chk("rst_nack",    int'(bus.nack_o), 0);
    chk("rst_ack_bit", int'(bus.ack_bit_o), 1);
    chk("rst_strobes", int'(strobes), 0);
    chk("rst_cnt",     int'(bus.counter_detect_edge_o), 0);
    chk("rst_rs_cnt",  int'(bus.counter_state_done_time_repeat_start_o), 0);
    chk("rst_txrx",    int'({bus.tx_req_o, bus.rx_valid_o}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table of complete transfers.
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      issue(vecs[v].addr_rw, vecs[v].nbytes, vecs[v].rs, vecs[v].presc, vecs[v].addr_nack);
      $display("vector %0d addr_rw=%02h", v, bus.addr_rw_i);
      chk($sformatf("v%0d_start_next", v), int'(bus.start_cnt_o), 1);
      chk($sformatf("v%0d_nack_clr", v),   int'(bus.nack_o), 0);
      chk($sformatf("v%0d_not_ready", v),  int'(bus.cmd_ready_o), 0);
      mon_en = 1'b1;
      wait_done($sformatf("v%0d", v));
      mon_en = 1'b0;
      chk($sformatf("v%0d_busy_cyc", v),  m_busy,     vecs[v].busy);
      chk($sformatf("v%0d_tx_req", v),    m_tx,       vecs[v].tx);
      chk($sformatf("v%0d_rx_valid", v),  m_rx,       vecs[v].rx);
      chk($sformatf("v%0d_done", v),      m_done,     vecs[v].done);
      chk($sformatf("v%0d_nack", v),      int'(bus.nack_o), vecs[v].nack);
      chk($sformatf("v%0d_scl_rises", v), m_rises,    vecs[v].rises);
      chk($sformatf("v%0d_ack_n", v),     m_ack_n,    vecs[v].ack_n);
      chk($sformatf("v%0d_ack_bits", v),  m_ack_hist, vecs[v].ack_hist);
      chk($sformatf("v%0d_stop_cyc", v),  m_stop,     vecs[v].stop_cyc);
      chk($sformatf("v%0d_data_cyc", v),  m_data,     vecs[v].data_cyc);
      chk($sformatf("v%0d_rack_cyc", v),  m_rack,     vecs[v].rack_cyc);
      chk($sformatf("v%0d_rs_cyc", v),    m_rs,       vecs[v].rs_cyc);
      chk($sformatf("v%0d_onehot", v),    m_onehot,   0);
      chk($sformatf("v%0d_ready", v),     int'(bus.cmd_ready_o), 1);
      chk($sformatf("v%0d_idle_scl", v),  int'(bus.scl_o), 1);
    end

    // Phase counter and SCL shape over START and the first address bit, P=4.
    issue(8'h22, 8'd1, 1'b0, 8'd4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("shape_cnt%0d", i), int'(bus.counter_detect_edge_o), i % 8);
      chk($sformatf("shape_scl%0d", i), int'(bus.scl_o), (i < 8) ? 1 : ((i % 8) >= 4 ? 1 : 0));
      if (i == 8) chk("shape_addr_strobe", int'(bus.write_addr_cnt_o), 1);
    end
    wait_done("shape");

    // Repeated-start window, P=2: SCL low 2 clocks, then down-counter 4..0.
    begin
      bit seen;
      int exp_rs[7];
      int exp_scl[7];
      exp_rs  = '{0, 0, 4, 3, 2, 1, 0};
      exp_scl = '{0, 0, 1, 1, 1, 1, 1};
      issue(8'h20, 8'd1, 1'b1, 8'd2, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (bus.repeat_start_cnt_o) seen = 1'b1;
      end
      chk("rs_entered", int'(seen), 1);
      for (int i = 0; i < 7; i++) begin
        if (i > 0) @(negedge clk);
        chk($sformatf("rs_cnt%0d", i), int'(bus.counter_state_done_time_repeat_start_o), exp_rs[i]);
        chk($sformatf("rs_scl%0d", i), int'(bus.scl_o), exp_scl[i]);
      end
      @(negedge clk);
      chk("rs_done",      int'(bus.done_o), 1);
      chk("rs_idle",      int'(bus.busy_o), 0);
      chk("rs_hold_zero", int'(bus.counter_state_done_time_repeat_start_o), 0);
      chk("rs_scl_high",  int'(bus.scl_o), 1);
      // Next command straight away: START the cycle after acceptance.
      bus.addr_rw_i      = 8'h20;
      bus.num_bytes_i    = 8'd1;
      bus.repeat_start_i = 1'b0;
      bus.prescaler_i    = 8'd2;
      bus.cmd_valid_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid_i = 1'b0;
      chk("rs_next_start", int'(bus.start_cnt_o), 1);
      chk("rs_cnt_holds",  int'(bus.counter_state_done_time_repeat_start_o), 0);
      wait_done("rs_next");
    end

    // Reset during WRITE_DATA aborts without a STOP phase.
    begin
      bit seen;
      issue(8'hA0, 8'd2, 1'b0, 8'd2, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (bus.write_data_cnt_o) seen = 1'b1;
      end
      chk("abort_in_wdata", int'(seen), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy",    int'(bus.busy_o), 0);
      chk("abort_strobes", int'(strobes), 0);
      chk("abort_scl",     int'(bus.scl_o), 1);
      chk("abort_ready",   int'(bus.cmd_ready_o), 1);
      chk("abort_cnt",     int'(bus.counter_detect_edge_o), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      mon_en = 1'b1;
      repeat (20) @(negedge clk);
      mon_en = 1'b0;
      @(negedge clk);
      chk("abort_no_stop", m_stop, 0);
      chk("abort_no_busy", m_busy, 0);
      chk("abort_no_done", m_done, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
